if_fetch_unit: RTL and testbench



---
 rtl/if_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 63 ++++++
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared widths, defaults, branch-mode encodings and the IF/ID payload type
// for the instruction-fetch stage.
package if_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    // Branch target interpretation: absolute address or offset from br_pc.
    localparam int BR_MODE_ABS = 0;
    localparam int BR_MODE_REL = 1;

    // IF/ID payload at default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [ADDR_W_DEF-1:0]  pc_next;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble clears only the valid bit and leaves the
// payload untouched; a hold keeps everything; otherwise the new fetch loads.
module if_id_reg
    import if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               bubble,
    input  logic [ADDR_W-1:0]  ld_pc,
    input  logic [ADDR_W-1:0]  ld_pc_next,
    input  logic [INSTR_W-1:0] ld_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    // Next payload: bubble beats hold, hold beats load.
    always_comb begin
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        if (bubble) begin
            valid_d = 1'b0;
        end else if (!hold) begin
            pc_d      = ld_pc;
            pc_next_d = ld_pc_next;
            instr_d   = ld_instr;
            valid_d   = 1'b1;
        end
    end

    // Payload register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            pc_next_q <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

    assign if_pc      = pc_q;
    assign if_pc_next = pc_next_q;
    assign if_instr   = instr_q;
    assign if_valid   = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// registers the fetched word into IF/ID. Define IF_PERF_CNT_EN to build the
// fetch/bubble performance counters; otherwise they read as zero.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                BR_REL   = BR_MODE_ABS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic [ADDR_W-1:0]  br_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_bubble_cnt
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] br_dest;
    logic              bubble;

    assign pc_seq = pc_q + ADDR_W'(PC_STEP);
    assign bubble = br_taken | flush;

    // Next PC: branch beats stall beats sequential; arithmetic wraps silently.
    always_comb begin
        br_dest = (BR_REL == BR_MODE_REL) ? (br_pc + br_target) : br_target;
        pc_d    = pc_seq;
        if (br_taken) begin
            pc_d = br_dest;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .bubble     (bubble),
        .ld_pc      (pc_q),
        .ld_pc_next (pc_seq),
        .ld_instr   (imem_rdata),
        .if_pc      (if_pc),
        .if_pc_next (if_pc_next),
        .if_instr   (if_instr),
        .if_valid   (if_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Count edges that load a real instruction or a bubble; hold edges count nothing.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else if (!stall) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    assign perf_fetch_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: three instances (default; relative branch with
// PC_STEP=4; 8-bit wrapping PC) driven by shared controls and checked
// against a cycle-level reference model, plus directed vectors.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, br_taken;
    logic [31:0] br_target, br_pc;

    logic [31:0] imem_addr_a, rdata_a, pc_a, if_pc_a, if_pc_next_a, if_instr_a, pf_a, pb_a;
    logic        if_valid_a;
    logic [31:0] imem_addr_b, rdata_b, pc_b, if_pc_b, if_pc_next_b, if_instr_b, pf_b, pb_b;
    logic        if_valid_b;
    logic [7:0]  imem_addr_c, pc_c, if_pc_c, if_pc_next_c;
    logic [31:0] rdata_c, if_instr_c, pf_c, pb_c;
    logic        if_valid_c;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rdata_a = mem_f(imem_addr_a);
    assign rdata_b = mem_f(imem_addr_b);
    assign rdata_c = mem_f({24'h0, imem_addr_c});

    if_fetch_unit dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
        .br_target(br_target), .br_pc(br_pc), .imem_addr(imem_addr_a), .imem_rdata(rdata_a),
        .pc(pc_a), .if_pc(if_pc_a), .if_pc_next(if_pc_next_a), .if_instr(if_instr_a),
        .if_valid(if_valid_a), .perf_fetch_cnt(pf_a), .perf_bubble_cnt(pb_a)
    );

    if_fetch_unit #(.PC_STEP(4), .BR_REL(BR_MODE_REL)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
        .br_target(br_target), .br_pc(br_pc), .imem_addr(imem_addr_b), .imem_rdata(rdata_b),
        .pc(pc_b), .if_pc(if_pc_b), .if_pc_next(if_pc_next_b), .if_instr(if_instr_b),
        .if_valid(if_valid_b), .perf_fetch_cnt(pf_b), .perf_bubble_cnt(pb_b)
    );

    if_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_taken(br_taken),
        .br_target(br_target[7:0]), .br_pc(br_pc[7:0]), .imem_addr(imem_addr_c), .imem_rdata(rdata_c),
        .pc(pc_c), .if_pc(if_pc_c), .if_pc_next(if_pc_next_c), .if_instr(if_instr_c),
        .if_valid(if_valid_c), .perf_fetch_cnt(pf_c), .perf_bubble_cnt(pb_c)
    );

    // Reference model state: fetch PC, IF/ID contents, event counts.
    typedef struct {
        logic [31:0] pc;
        if_id_t      ifid;
        logic [31:0] fcnt;
        logic [31:0] bcnt;
    } mstate_t;

    mstate_t ms_a, ms_b, ms_c;

    function automatic mstate_t step(input mstate_t s, input logic r, st, fl, br,
                                     input logic [31:0] tgt, bpc,
                                     input int pstep, input bit rel,
                                     input logic [31:0] mask, input logic [31:0] rpc);
        mstate_t n = s;
        if (r) begin
            n.pc = rpc;
            n.ifid = '0;
            n.fcnt = 0;
            n.bcnt = 0;
        end else begin
            if (br)       n.pc = (rel ? (bpc + tgt) : tgt) & mask;
            else if (!st) n.pc = (s.pc + pstep) & mask;
            if (br || fl) begin
                n.ifid.valid = 1'b0;
                n.bcnt = s.bcnt + 1;
            end else if (!st) begin
                n.ifid.pc      = s.pc;
                n.ifid.pc_next = (s.pc + pstep) & mask;
                n.ifid.instr   = mem_f(s.pc);
                n.ifid.valid   = 1'b1;
                n.fcnt = s.fcnt + 1;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input mstate_t m,
                             input logic [31:0] p, ad, ip, ipn, ins, input logic v,
                             input logic [31:0] pf, pb);
        logic [31:0] ef, eb;
`ifdef IF_PERF_CNT_EN
        ef = m.fcnt;
        eb = m.bcnt;
`else
        ef = 0;
        eb = 0;
`endif
        check({tag, ".pc"}, p, m.pc);
        check({tag, ".imem_addr"}, ad, m.pc);
        check({tag, ".if_pc"}, ip, m.ifid.pc);
        check({tag, ".if_pc_next"}, ipn, m.ifid.pc_next);
        check({tag, ".if_instr"}, ins, m.ifid.instr);
        check({tag, ".if_valid"}, {31'h0, v}, {31'h0, m.ifid.valid});
        check({tag, ".perf_fetch"}, pf, ef);
        check({tag, ".perf_bubble"}, pb, eb);
    endtask

    task automatic cycle(input logic r, s, f, b, input logic [31:0] t, p, input string tag);
        rst = r; stall = s; flush = f; br_taken = b; br_target = t; br_pc = p;
        @(posedge clk);
        ms_a = step(ms_a, r, s, f, b, t, p, 1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        ms_b = step(ms_b, r, s, f, b, t, p, 4, 1'b1, 32'hFFFF_FFFF, 32'h0);
        ms_c = step(ms_c, r, s, f, b, t, p, 1, 1'b0, 32'h0000_00FF, 32'h0000_00FE);
        #1;
        check_dut({tag, ".a"}, ms_a, pc_a, imem_addr_a, if_pc_a, if_pc_next_a, if_instr_a, if_valid_a, pf_a, pb_a);
        check_dut({tag, ".b"}, ms_b, pc_b, imem_addr_b, if_pc_b, if_pc_next_b, if_instr_b, if_valid_b, pf_b, pb_b);
        check_dut({tag, ".c"}, ms_c, {24'h0, pc_c}, {24'h0, imem_addr_c}, {24'h0, if_pc_c},
                  {24'h0, if_pc_next_c}, if_instr_c, if_valid_c, pf_c, pb_c);
    endtask

    typedef struct {
        logic        r, s, f, b;
        logic [31:0] t;
        logic [31:0] exp_pc;
        logic        exp_v;
        logic [31:0] exp_if_pc;
    } vec_t;

    vec_t vecs[20];

    initial begin
        ms_a = '{default: '0};
        ms_b = '{default: '0};
        ms_c = '{default: '0};

        // Directed vectors for the default instance (step 1, absolute branch).
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h01, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h02, 1'b1, 32'h01};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h03, 1'b1, 32'h02};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h04, 1'b1, 32'h03};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h05, 1'b1, 32'h04};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0, 32'h04};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h41, 1'b1, 32'h40};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h42, 1'b1, 32'h41};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h07, 32'h07, 1'b0, 32'h41};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h07};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h07};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h07};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h07};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h20, 1'b0, 32'h07};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h20, 1'b0, 32'h07};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h21, 1'b0, 32'h07};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h22, 1'b1, 32'h21};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00};

        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].t, 32'h0, "vec");
            check($sformatf("vec%0d.pc", i), pc_a, vecs[i].exp_pc);
            check($sformatf("vec%0d.if_valid", i), {31'h0, if_valid_a}, {31'h0, vecs[i].exp_v});
            check($sformatf("vec%0d.if_pc", i), if_pc_a, vecs[i].exp_if_pc);
            if (i == 8) begin
                check("vec8.if_pc_next", if_pc_next_a, 32'h41);
                check("vec8.if_instr", if_instr_a, mem_f(32'h40));
            end
        end

        // Relative branch on the PC_STEP=4 instance: 0x100 + (-16).
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "rel");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "rel");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h100, "rel");
        check("rel.pc", pc_b, 32'hF0);
        check("rel.bubble", {31'h0, if_valid_b}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "rel");
        check("rel.if_pc", if_pc_b, 32'hF0);
        check("rel.if_pc_next", if_pc_next_b, 32'hF4);
        check("rel.if_valid", {31'h0, if_valid_b}, 32'h1);

        // 8-bit PC wrap and mid-stream reset.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");
        check("wrap.pc0", {24'h0, pc_c}, 32'hFE);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");
        check("wrap.pc1", {24'h0, pc_c}, 32'hFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");
        check("wrap.pc2", {24'h0, pc_c}, 32'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");
        check("wrap.pc5", {24'h0, pc_c}, 32'h05);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");
        check("wrap.rst_pc", {24'h0, pc_c}, 32'hFE);
        check("wrap.rst_valid", {31'h0, if_valid_c}, 32'h0);

        // Performance counters: 10 fetches, 1 flush, 2 stalls.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "perf");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "perf");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "perf");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "perf");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "perf");
`ifdef IF_PERF_CNT_EN
        check("perf.fetch", pf_a, 32'd10);
        check("perf.bubble", pb_a, 32'd1);
`else
        check("perf.fetch", pf_a, 32'd0);
        check("perf.bubble", pb_a, 32'd0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom, $urandom, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
